// File: rtl/add_serial_pkg.sv
// rtl/add_serial_pkg.sv - shared state encoding and helpers for the serial add scheduler
//
// Contents:
//   state_t  : FSM state type, IDLE=0, ADD=1, DONE=2 (encoding 3 is unused and
//              falls back to IDLE in the scheduler).
//   maj3()   : majority of three bits, the full-adder carry function.
package add_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/add_serial_rr_arb.sv
// rtl/add_serial_rr_arb.sv - round-robin arbiter choosing the next requester for the serial adder
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset; requester 0 gets top priority
//   req      in   [NREQ] request vector
//   advance  in   grant accepted this cycle; pointer moves past gnt_idx
//   gnt_idx  out  index of the selected requester (valid only when valid=1)
//   valid    out  at least one request is pending
module add_serial_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic                    advance,
  output logic [$clog2(NREQ)-1:0] gnt_idx,
  output logic                    valid
);

  localparam int IW = $clog2(NREQ);

  // Index of the requester with highest priority in the next arbitration.
  logic [IW-1:0] r_ptr;

  // (p + off) mod NREQ, valid for p < NREQ and off <= NREQ; handles non power of two NREQ.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Scan from the farthest offset down to offset 0 so the nearest pending
  // requester to the pointer is the last (winning) assignment.
  always_comb begin
    valid   = 1'b0;
    gnt_idx = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req[wrap_add(r_ptr, off)]) begin
        valid   = 1'b1;
        gnt_idx = wrap_add(r_ptr, off);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance && valid) begin
      r_ptr <= wrap_add(gnt_idx, 1);
    end
  end

endmodule

// File: rtl/add_serial_sched.sv
// rtl/add_serial_sched.sv - bit-serial adder shared by NREQ requesters under round-robin scheduling
//
// Optional feature macro: ADD_SERIAL_SCHED_COUT_EN (adds the cout output).
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, aborts any operation
//   req      in   [NREQ] level requests, held until granted
//   a, b     in   [NREQ*WIDTH] operands, requester i at [i*WIDTH +: WIDTH]
//   gnt      out  [NREQ] one-hot pulse in the first ADD cycle
//   busy     out  state is not IDLE
//   done     out  one-cycle pulse, out/done_id valid
//   done_id  out  requester whose sum is on out
//   out      out  [WIDTH] sum modulo 2^WIDTH, held until the next operation starts
//   cout     out  final carry, valid with done (only with ADD_SERIAL_SCHED_COUT_EN)
module add_serial_sched
  import add_serial_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a,
  input  logic [NREQ*WIDTH-1:0]   b,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [WIDTH-1:0]        out
`ifdef ADD_SERIAL_SCHED_COUT_EN
  ,
  output logic                    cout
`endif
);

  localparam int             IW   = $clog2(NREQ);
  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_out;
  logic            r_carry;
  logic [CW-1:0]   r_count;
  logic [NREQ-1:0] r_gnt;
  logic [IW-1:0]   r_done_id;

  logic            w_arb_valid;
  logic [IW-1:0]   w_arb_idx;
  logic            w_arb_adv;
  logic [WIDTH-1:0] w_a_sel;
  logic [WIDTH-1:0] w_b_sel;
  logic [NREQ-1:0] w_gnt_onehot;
  logic            w_sum;
  logic            w_carry_nxt;
  logic            w_last;

  // The pointer only moves when a grant is actually taken, i.e. in IDLE.
  assign w_arb_adv = (r_state == IDLE) && w_arb_valid;

  add_serial_rr_arb #(
    .NREQ(NREQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (w_arb_adv),
    .gnt_idx (w_arb_idx),
    .valid   (w_arb_valid)
  );

  // Operand mux and one-hot decode of the arbiter's choice.
  always_comb begin
    w_a_sel      = '0;
    w_b_sel      = '0;
    w_gnt_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_arb_idx == IW'(i)) begin
        w_a_sel         = a[i*WIDTH +: WIDTH];
        w_b_sel         = b[i*WIDTH +: WIDTH];
        w_gnt_onehot[i] = 1'b1;
      end
    end
  end

  assign w_sum       = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry_nxt = maj3(r_a[0], r_b[0], r_carry);
  assign w_last      = (r_count == LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE:    w_state_nxt = w_arb_valid ? ADD : IDLE;
      ADD:     w_state_nxt = w_last ? DONE : ADD;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_out     <= '0;
      r_carry   <= 1'b0;
      r_count   <= '0;
      r_gnt     <= '0;
      r_done_id <= '0;
    end else begin
      r_gnt <= '0;
      case (r_state)
        IDLE: begin
          if (w_arb_valid) begin
            r_a       <= w_a_sel;
            r_b       <= w_b_sel;
            r_out     <= '0;
            r_carry   <= 1'b0;
            r_count   <= '0;
            r_done_id <= w_arb_idx;
            r_gnt     <= w_gnt_onehot;
          end
        end
        ADD: begin
          // Sum bits enter at the MSB so after WIDTH shifts bit 0 holds the first sum.
          r_out   <= {w_sum, r_out[WIDTH-1:1]};
          r_carry <= w_carry_nxt;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_count <= r_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ADD_SERIAL_SCHED_COUT_EN
  // Kept separately because r_carry is cleared when the next operation is captured.
  logic r_cout;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cout <= 1'b0;
    end else if (r_state == ADD && w_last) begin
      r_cout <= w_carry_nxt;
    end
  end
  assign cout = r_cout;
`endif

  assign gnt     = r_gnt;
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign done_id = r_done_id;
  assign out     = r_out;

endmodule

// File: tb/tb_add_serial_sched.sv
// tb/tb_add_serial_sched.sv - directed self-checking bench for add_serial_sched
module tb_add_serial_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic [7:0]  out;
`ifdef ADD_SERIAL_SCHED_COUT_EN
  logic        cout;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  add_serial_sched #(
    .NREQ  (4),
    .WIDTH (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .a       (a),
    .b       (b),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .out     (out)
`ifdef ADD_SERIAL_SCHED_COUT_EN
    ,
    .cout    (cout)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = '0;
    a   = '0;
    b   = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 4'hF;
    a   = '1;
    b   = '1;
    tick();
    tick();
    n_cmp++; if (out !== 8'h00)   begin n_err++; $display("FAIL reset_out got=%h exp=00", out); end
    n_cmp++; if (gnt !== 4'h0)    begin n_err++; $display("FAIL reset_gnt got=%h exp=0", gnt); end
    n_cmp++; if (done !== 1'b0)   begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done_id !== 2'd0) begin n_err++; $display("FAIL reset_done_id got=%0d exp=0", done_id); end
    rst = 1'b0;
    req = '0;
  endtask

  task automatic test_single;
    do_reset();
    req = 4'b0100;
    a[16 +: 8] = 8'h5A;
    b[16 +: 8] = 8'h33;
    tick();
    n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt got=%h exp=4", gnt); end
    n_cmp++; if (busy !== 1'b1)   begin n_err++; $display("FAIL single_busy got=%b exp=1", busy); end
    // Operand changes during the operation must not disturb it.
    req = '0;
    a   = '1;
    b   = 32'h1234_5678;
    tick();
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL single_gnt_pulse got=%h exp=0", gnt); end
    repeat (6) tick();
    n_cmp++; if (done !== 1'b0)   begin n_err++; $display("FAIL single_early_done got=%b exp=0", done); end
    tick();
    n_cmp++; if (done !== 1'b1)    begin n_err++; $display("FAIL single_done got=%b exp=1", done); end
    n_cmp++; if (out !== 8'h8D)    begin n_err++; $display("FAIL single_out got=%h exp=8d", out); end
    n_cmp++; if (done_id !== 2'd2) begin n_err++; $display("FAIL single_done_id got=%0d exp=2", done_id); end
`ifdef ADD_SERIAL_SCHED_COUT_EN
    n_cmp++; if (cout !== 1'b0)    begin n_err++; $display("FAIL single_cout got=%b exp=0", cout); end
`endif
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL single_done_pulse got=%b exp=0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle got=%b exp=0", busy); end
    n_cmp++; if (out !== 8'h8D) begin n_err++; $display("FAIL single_out_hold got=%h exp=8d", out); end
  endtask

  task automatic test_overflow;
    do_reset();
    req = 4'b0001;
    a[7:0] = 8'hFF;
    b[7:0] = 8'h01;
    tick();
    req = '0;
    repeat (8) tick();
    n_cmp++; if (done !== 1'b1)    begin n_err++; $display("FAIL ovf_done got=%b exp=1", done); end
    n_cmp++; if (out !== 8'h00)    begin n_err++; $display("FAIL ovf_out got=%h exp=00", out); end
    n_cmp++; if (done_id !== 2'd0) begin n_err++; $display("FAIL ovf_done_id got=%0d exp=0", done_id); end
`ifdef ADD_SERIAL_SCHED_COUT_EN
    n_cmp++; if (cout !== 1'b1)    begin n_err++; $display("FAIL ovf_cout got=%b exp=1", cout); end
    tick();
    n_cmp++; if (cout !== 1'b1)    begin n_err++; $display("FAIL ovf_cout_hold got=%b exp=1", cout); end
`endif
  endtask

  task automatic test_round_robin;
    int         exp_order [5] = '{0, 1, 2, 3, 0};
    int         exp_cyc   [5] = '{1, 11, 21, 31, 41};
    logic [7:0] av [4] = '{8'h91, 8'h2B, 8'h7F, 8'hC8};
    logic [7:0] bv [4] = '{8'h10, 8'hE5, 8'h01, 8'h64};
    logic [7:0] sums [4];
    logic [3:0] exp_gnt;
    int         ng = 0;
    int         nd = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a[i*8 +: 8] = av[i];
      b[i*8 +: 8] = bv[i];
      sums[i]     = av[i] + bv[i];
    end
    req = 4'hF;
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (gnt !== 4'h0) begin
        if (ng < 5) begin
          exp_gnt = 4'b0001 << exp_order[ng];
          n_cmp++; if (gnt !== exp_gnt) begin n_err++; $display("FAIL rr_gnt%0d got=%h exp=%h", ng, gnt, exp_gnt); end
          n_cmp++; if (c != exp_cyc[ng]) begin n_err++; $display("FAIL rr_gnt_cycle%0d got=%0d exp=%0d", ng, c, exp_cyc[ng]); end
        end
        ng++;
      end
      if (done === 1'b1) begin
        if (nd < 4) begin
          n_cmp++; if (done_id !== 2'(exp_order[nd])) begin n_err++; $display("FAIL rr_done_id%0d got=%0d exp=%0d", nd, done_id, exp_order[nd]); end
          n_cmp++; if (out !== sums[exp_order[nd]]) begin n_err++; $display("FAIL rr_out%0d got=%h exp=%h", nd, out, sums[exp_order[nd]]); end
        end
        nd++;
      end
    end
    n_cmp++; if (ng != 5) begin n_err++; $display("FAIL rr_grant_count got=%0d exp=5", ng); end
    n_cmp++; if (nd != 4) begin n_err++; $display("FAIL rr_done_count got=%0d exp=4", nd); end
    req = '0;
  endtask

  task automatic test_abort;
    do_reset();
    req = 4'b0100;
    a[16 +: 8] = 8'h5A;
    b[16 +: 8] = 8'h33;
    tick();
    req = '0;
    repeat (3) tick();
    // Now in the 4th ADD cycle; requesters 1 and 3 become pending.
    rst = 1'b1;
    req = 4'b1010;
    a[8 +: 8]  = 8'h12;
    b[8 +: 8]  = 8'h34;
    a[24 +: 8] = 8'h01;
    b[24 +: 8] = 8'h02;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy); end
    n_cmp++; if (out !== 8'h00) begin n_err++; $display("FAIL abort_out got=%h exp=00", out); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done got=%b exp=0", done); end
    n_cmp++; if (gnt !== 4'h0)  begin n_err++; $display("FAIL abort_gnt got=%h exp=0", gnt); end
    rst = 1'b0;
    tick();
    n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL abort_next_gnt got=%h exp=2", gnt); end
    req = '0;
    repeat (8) tick();
    n_cmp++; if (done !== 1'b1)    begin n_err++; $display("FAIL abort_next_done got=%b exp=1", done); end
    n_cmp++; if (out !== 8'h46)    begin n_err++; $display("FAIL abort_next_out got=%h exp=46", out); end
    n_cmp++; if (done_id !== 2'd1) begin n_err++; $display("FAIL abort_next_id got=%0d exp=1", done_id); end
  endtask

  task automatic test_fairness;
    logic [3:0] exp_g [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    int         ng = 0;
    do_reset();
    req = 4'b1010;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (gnt !== 4'h0) begin
        if (ng < 4) begin
          n_cmp++; if (gnt !== exp_g[ng]) begin n_err++; $display("FAIL fair_gnt%0d got=%h exp=%h", ng, gnt, exp_g[ng]); end
        end
        ng++;
      end
    end
    n_cmp++; if (ng != 4) begin n_err++; $display("FAIL fair_grant_count got=%0d exp=4", ng); end
    req = '0;
  endtask

  task automatic test_drop;
    do_reset();
    req = 4'b0011;
    tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL drop_first_gnt got=%h exp=1", gnt); end
    // Requester 1 withdraws; requester 0 keeps asking and is served again.
    req = 4'b0001;
    repeat (10) tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL drop_regrant got=%h exp=1", gnt); end
    req = '0;
    repeat (10) tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_idle got=%b exp=0", busy); end
    n_cmp++; if (gnt !== 4'h0)  begin n_err++; $display("FAIL drop_no_gnt got=%h exp=0", gnt); end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    a   = '0;
    b   = '0;
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_abort();
    test_fairness();
    test_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
